// File: rtl/if_id_stage.sv
// Fetch stage and IF/ID pipeline register: owns the PC, computes PC+2, applies
// hazard stalls and ID-resolved redirects, and stops fetching on HLT.
//
// state   | meaning
// --------+------------------------------------------------------------
// FETCH   | fetching sequentially; PC advances by 2 each unstalled edge
// HALTED  | HLT captured; PC frozen, IF/ID filled with bubbles until redirect
module if_id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  input  logic [15:0] imem_data,
  output logic [15:0] imem_addr,
  output logic [15:0] ID_instr,
  output logic [15:0] ID_PC_INC_OUT,
  output logic        ID_valid,
  output logic        fetch_halted,
  output logic [15:0] fetch_count
);

  typedef enum logic {
    S_FETCH  = 1'b0,
    S_HALTED = 1'b1
  } state_t;

  localparam logic [3:0] OP_HLT = 4'hF;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] pc_inc_q, pc_inc_d;
  logic        valid_q, valid_d;
  logic [15:0] count_q, count_d;
  logic [15:0] pc_plus2;

  assign pc_plus2 = pc_q + 16'd2;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= 16'h0000;
      instr_q  <= 16'h0000;
      pc_inc_q <= 16'h0000;
      valid_q  <= 1'b0;
      count_q  <= 16'h0000;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_inc_q <= pc_inc_d;
      valid_q  <= valid_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_inc_d = pc_inc_q;
    valid_d  = valid_q;
    count_d  = count_q;

    if (stall) begin
      // hold everything; a branch seen under stall is re-presented later
    end else if (branch_taken) begin
      // an older branch in ID overrides whatever was just fetched, HLT included
      pc_d     = {branch_target[15:1], 1'b0};
      instr_d  = 16'h0000;
      pc_inc_d = 16'h0000;
      valid_d  = 1'b0;
      state_d  = S_FETCH;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          instr_d  = imem_data;
          pc_inc_d = pc_plus2;
          valid_d  = 1'b1;
          count_d  = count_q + 16'd1;
          if (imem_data[15:12] == OP_HLT) begin
            state_d = S_HALTED;
          end else begin
            pc_d = pc_plus2;
          end
        end
        S_HALTED: begin
          instr_d = 16'h0000;
          valid_d = 1'b0;
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  assign imem_addr     = pc_q;
  assign ID_instr      = instr_q;
  assign ID_PC_INC_OUT = pc_inc_q;
  assign ID_valid      = valid_q;
  assign fetch_halted  = (state_q == S_HALTED);
  assign fetch_count   = count_q;

endmodule
